// File: rtl/cdtv_subcode_rx.sv
// CD-ROM subcode receiver: synchronises EFFK/SCOR/SBCP, drives a bounded SCCK burst per EFFK,
// deserialises SBCP MSB-first into symbols and queues them with frame tags in a small FIFO.
module cdtv_subcode_rx #(
    parameter int BITS_PER_SYM = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int SCCK_DIV     = 1,
    parameter int FRAME_SYMS   = 98
) (
    input  logic                        CCK,
    input  logic                        RST,
    input  logic                        EFFK,
    input  logic                        SCOR,
    input  logic                        SBCP,
    output logic                        SCCK,
    output logic [BITS_PER_SYM-1:0]     DOUT,
    output logic                        DSOF,
    output logic [6:0]                  DIDX,
    output logic                        DVALID,
    input  logic                        DREADY,
    output logic [$clog2(FIFO_DEPTH):0] FILL,
    output logic                        BUSY,
    output logic                        OVF,
    output logic                        BERR,
    input  logic                        CLR_ERR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SCCK_DIV + 1);
    localparam int BW = $clog2(BITS_PER_SYM + 1);
    localparam int WW = BITS_PER_SYM + 8;
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCCK_DIV - 1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(BITS_PER_SYM);
    localparam logic [6:0]    IDX_LAST  = 7'(FRAME_SYMS - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_PUSH} state_t;

    logic effk_s1_q, effk_s2_q, effk_s3_q, effk_rise_q, effk_rise_d;
    logic scor_s1_q, scor_s2_q, scor_s3_q, scor_rise_q, scor_rise_d;
    logic sbcp_s1_q, sbcp_s2_q;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic [BW-1:0]           bits_q, bits_d;
    logic [BITS_PER_SYM-1:0] sh_q, sh_d;
    logic                    scck_q, scck_d;
    logic                    pend_q, pend_d;
    logic                    arm_q, arm_d;
    logic [6:0]              idx_q, idx_d, idx_inc;
    logic                    push, busy, berr_set;

    logic [WW-1:0]           mem_q [FIFO_DEPTH];
    logic [WW-1:0]           head_w;
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             fill_q, fill_d;
    logic                    full, pop, wr_en, ovf_set;
    logic                    ovf_q, ovf_d, berr_q, berr_d;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bits_d      = bits_q;
        sh_d        = sh_q;
        scck_d      = scck_q;
        pend_d      = pend_q;
        arm_d       = arm_q;
        idx_d       = idx_q;
        push        = 1'b0;
        effk_rise_d = effk_s2_q & ~effk_s3_q;
        scor_rise_d = scor_s2_q & ~scor_s3_q;
        busy        = (state_q != S_IDLE);
        berr_set    = effk_rise_q & busy;
        idx_inc     = (idx_q == IDX_LAST) ? 7'd0 : idx_q + 7'd1;

        unique case (state_q)
            S_IDLE: begin
                if (effk_rise_q) begin
                    state_d = S_HI;
                    div_d   = '0;
                    bits_d  = '0;
                    scck_d  = 1'b1;
                end
            end
            S_HI: begin
                if (div_q == DIV_LAST) begin
                    sh_d    = {sh_q[BITS_PER_SYM-2:0], sbcp_s2_q};
                    bits_d  = bits_q + BW'(1);
                    div_d   = '0;
                    scck_d  = 1'b0;
                    state_d = S_LO;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bits_q < BITS_ALL) begin
                        state_d = S_HI;
                        scck_d  = 1'b1;
                    end else begin
                        state_d = S_PUSH;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A SCOR seen mid-burst is parked in arm_q so the symbol in flight keeps its old tag.
        if (state_q == S_PUSH) begin
            pend_d = arm_q | scor_rise_q;
            idx_d  = (arm_q | scor_rise_q) ? 7'd0 : idx_inc;
            arm_d  = 1'b0;
        end else if (scor_rise_q) begin
            if (state_q == S_IDLE) begin
                pend_d = 1'b1;
                idx_d  = 7'd0;
            end else begin
                arm_d = 1'b1;
            end
        end
    end

    always_comb begin
        full    = (fill_q == FIFO_FULL);
        pop     = (fill_q != '0) & DREADY;
        wr_en   = push & (~full | pop);
        ovf_set = push & full & ~pop;
        wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + (AW + 1)'(1);
            2'b01:   fill_d = fill_q - (AW + 1)'(1);
            default: fill_d = fill_q;
        endcase
        ovf_d  = (ovf_q & ~CLR_ERR) | ovf_set;
        berr_d = (berr_q & ~CLR_ERR) | berr_set;
    end

    always_ff @(posedge CCK) begin
        if (RST) begin
            effk_s1_q   <= 1'b0;
            effk_s2_q   <= 1'b0;
            effk_s3_q   <= 1'b0;
            effk_rise_q <= 1'b0;
            scor_s1_q   <= 1'b0;
            scor_s2_q   <= 1'b0;
            scor_s3_q   <= 1'b0;
            scor_rise_q <= 1'b0;
            sbcp_s1_q   <= 1'b0;
            sbcp_s2_q   <= 1'b0;
            state_q     <= S_IDLE;
            div_q       <= '0;
            bits_q      <= '0;
            scck_q      <= 1'b0;
            pend_q      <= 1'b0;
            arm_q       <= 1'b0;
            idx_q       <= 7'd0;
            wr_q        <= '0;
            rd_q        <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            effk_s1_q   <= EFFK;
            effk_s2_q   <= effk_s1_q;
            effk_s3_q   <= effk_s2_q;
            effk_rise_q <= effk_rise_d;
            scor_s1_q   <= SCOR;
            scor_s2_q   <= scor_s1_q;
            scor_s3_q   <= scor_s2_q;
            scor_rise_q <= scor_rise_d;
            sbcp_s1_q   <= SBCP;
            sbcp_s2_q   <= sbcp_s1_q;
            state_q     <= state_d;
            div_q       <= div_d;
            bits_q      <= bits_d;
            scck_q      <= scck_d;
            pend_q      <= pend_d;
            arm_q       <= arm_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            berr_q      <= berr_d;
        end
    end

    // Symbol storage is pure data; validity is tracked by the pointers and fill count.
    always_ff @(posedge CCK) begin
        sh_q <= sh_d;
        if (wr_en) mem_q[wr_q] <= {sh_q, pend_q, idx_q};
    end

    assign head_w = mem_q[rd_q];
    assign DVALID = (fill_q != '0);
    assign DOUT   = DVALID ? head_w[WW-1 -: BITS_PER_SYM] : '0;
    assign DSOF   = DVALID & head_w[7];
    assign DIDX   = DVALID ? head_w[6:0] : 7'd0;
    assign FILL   = fill_q;
    assign SCCK   = scck_q;
    assign BUSY   = busy;
    assign OVF    = ovf_q;
    assign BERR   = berr_q;

endmodule
